// File: rtl/prelude_loader_pkg.sv
//============================================================================
// Module   : prelude_loader_pkg
// Brief    : Shared types and constants for the Prelude serial program loader.
//            GET_SUM exists only when PRELUDE_LOADER_CHECKSUM_EN is defined.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

package prelude_loader_pkg;

    localparam int ADDR_W  = 8;
    localparam int DATA_W  = 8;
    localparam int COUNT_W = ADDR_W + 1;

    localparam logic [DATA_W-1:0] SYNC_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        WAIT_SYNC = 3'd0,
        GET_LEN   = 3'd1,
        GET_DATA  = 3'd2,
`ifdef PRELUDE_LOADER_CHECKSUM_EN
        GET_SUM   = 3'd3,
`endif
        DONE      = 3'd4,
        ERROR     = 3'd5
    } loader_state_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    // A length byte of zero encodes a full 256-byte image.
    function automatic logic [COUNT_W-1:0] decode_length(input logic [DATA_W-1:0] len);
        return (len == '0) ? {1'b1, {DATA_W{1'b0}}} : {1'b0, len};
    endfunction

    function automatic logic state_is_busy(input loader_state_t s);
        return (s == GET_LEN) || (s == GET_DATA)
`ifdef PRELUDE_LOADER_CHECKSUM_EN
            || (s == GET_SUM)
`endif
            ;
    endfunction

endpackage

`default_nettype wire

// File: rtl/prelude_loader_uart_rx.sv
//============================================================================
// Module   : uart_rx
// Brief    : 8N1 UART receiver with 2-flop synchroniser; pulses rx_valid on a
//            good stop bit, rx_ferr on a low stop bit.
//            Unaffected by PRELUDE_LOADER_CHECKSUM_EN.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module uart_rx
    import prelude_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 234
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              uart_rx,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              rx_ferr
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] c_half_m1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] c_full_m1 = CNT_W'(CLKS_PER_BIT - 1);

    logic [1:0]        r_sync;
    logic              r_rx_prev;
    rx_state_t         r_state;
    rx_state_t         w_state_next;
    logic [CNT_W-1:0]  r_cnt;
    logic [2:0]        r_bit_idx;
    logic [DATA_W-1:0] r_shift;

    logic w_rx;
    logic w_start_edge;
    logic w_half_tick;
    logic w_bit_tick;

    assign w_rx         = r_sync[1];
    assign w_start_edge = r_rx_prev & ~w_rx;
    assign w_half_tick  = (r_cnt == c_half_m1);
    assign w_bit_tick   = (r_cnt == c_full_m1);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync    <= 2'b11;
            r_rx_prev <= 1'b1;
            r_state   <= RX_IDLE;
        end else begin
            r_sync    <= {r_sync[0], uart_rx};
            r_rx_prev <= w_rx;
            r_state   <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            RX_IDLE:  if (w_start_edge) w_state_next = RX_START;
            RX_START: if (w_half_tick)  w_state_next = w_rx ? RX_IDLE : RX_DATA;
            RX_DATA:  if (w_bit_tick && (r_bit_idx == 3'd7)) w_state_next = RX_STOP;
            RX_STOP:  if (w_bit_tick)   w_state_next = RX_IDLE;
            default:  w_state_next = RX_IDLE;
        endcase
    end

    // The bit counter restarts on every state change and every data-bit sample.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            rx_ferr   <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            rx_ferr  <= 1'b0;
            if ((r_state == RX_IDLE) || (w_state_next != r_state) || w_bit_tick) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (r_state == RX_START) begin
                r_bit_idx <= '0;
            end
            if ((r_state == RX_DATA) && w_bit_tick) begin
                r_shift   <= {w_rx, r_shift[DATA_W-1:1]};
                r_bit_idx <= r_bit_idx + 3'd1;
            end
            if ((r_state == RX_STOP) && w_bit_tick) begin
                if (w_rx) begin
                    rx_valid <= 1'b1;
                    rx_data  <= r_shift;
                end else begin
                    rx_ferr <= 1'b1;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/prelude_loader.sv
//============================================================================
// Module   : prelude_loader
// Brief    : Loads a framed UART program image into the Prelude program RAM
//            and holds the CPU in reset until a complete image is stored.
//            Define PRELUDE_LOADER_CHECKSUM_EN to require a trailing checksum.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module prelude_loader
    import prelude_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 234
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              uart_rx,
    output logic              prog_we,
    output logic [ADDR_W-1:0] prog_addr,
    output logic [DATA_W-1:0] prog_data,
    output logic              cpu_reset,
    output logic              busy,
    output logic              load_done,
    output logic              load_error
);

    logic [DATA_W-1:0]  w_rx_data;
    logic               w_rx_valid;
    logic               w_rx_ferr;

    loader_state_t      r_state;
    loader_state_t      w_state_next;
    logic [COUNT_W-1:0] r_count;
`ifdef PRELUDE_LOADER_CHECKSUM_EN
    logic [DATA_W-1:0]  r_sum;
`endif

    logic w_is_sync;
    logic w_len_byte;
    logic w_data_byte;
    logic w_last_byte;

    uart_rx #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_uart_rx (
        .clk      (clk),
        .reset    (reset),
        .uart_rx  (uart_rx),
        .rx_data  (w_rx_data),
        .rx_valid (w_rx_valid),
        .rx_ferr  (w_rx_ferr)
    );

    assign w_is_sync   = w_rx_valid && (w_rx_data == SYNC_BYTE);
    assign w_len_byte  = w_rx_valid && (r_state == GET_LEN);
    assign w_data_byte = w_rx_valid && (r_state == GET_DATA);
    assign w_last_byte = w_data_byte && (r_count == COUNT_W'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= WAIT_SYNC;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            WAIT_SYNC, DONE, ERROR: begin
                if (w_is_sync) w_state_next = GET_LEN;
            end
            GET_LEN: begin
                if (w_rx_ferr)       w_state_next = ERROR;
                else if (w_rx_valid) w_state_next = GET_DATA;
            end
            GET_DATA: begin
                if (w_rx_ferr) begin
                    w_state_next = ERROR;
                end else if (w_last_byte) begin
`ifdef PRELUDE_LOADER_CHECKSUM_EN
                    w_state_next = GET_SUM;
`else
                    w_state_next = DONE;
`endif
                end
            end
`ifdef PRELUDE_LOADER_CHECKSUM_EN
            GET_SUM: begin
                if (w_rx_ferr)       w_state_next = ERROR;
                else if (w_rx_valid) w_state_next = (w_rx_data == r_sum) ? DONE : ERROR;
            end
`endif
            default: w_state_next = WAIT_SYNC;
        endcase
    end

    // Status outputs are registered from the next state so they change one
    // cycle after the deciding byte, together with the state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count    <= '0;
            prog_we    <= 1'b0;
            prog_addr  <= '0;
            prog_data  <= '0;
            cpu_reset  <= 1'b1;
            busy       <= 1'b0;
            load_done  <= 1'b0;
            load_error <= 1'b0;
        end else begin
            prog_we <= w_data_byte;
            if (w_data_byte) begin
                prog_data <= w_rx_data;
                r_count   <= r_count - COUNT_W'(1);
            end
            if (w_len_byte) begin
                r_count   <= decode_length(w_rx_data);
                prog_addr <= '0;
            end else if (prog_we) begin
                prog_addr <= prog_addr + ADDR_W'(1);
            end
            cpu_reset  <= (w_state_next != DONE);
            busy       <= state_is_busy(w_state_next);
            load_done  <= (w_state_next == DONE);
            load_error <= (w_state_next == ERROR);
        end
    end

`ifdef PRELUDE_LOADER_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sum <= '0;
        end else if (w_len_byte) begin
            r_sum <= '0;
        end else if (w_data_byte) begin
            r_sum <= r_sum + w_rx_data;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_prelude_loader.sv
//============================================================================
// Module   : tb_prelude_loader
// Brief    : Scoreboard bench for prelude_loader; follows the frame format
//            selected by PRELUDE_LOADER_CHECKSUM_EN.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_prelude_loader;

    localparam int CPB = 4;
`ifdef PRELUDE_LOADER_CHECKSUM_EN
    localparam bit HAS_SUM = 1'b1;
`else
    localparam bit HAS_SUM = 1'b0;
`endif

    logic       clk     = 1'b0;
    logic       reset   = 1'b1;
    logic       uart_rx = 1'b1;
    logic       prog_we;
    logic [7:0] prog_addr;
    logic [7:0] prog_data;
    logic       cpu_reset;
    logic       busy;
    logic       load_done;
    logic       load_error;

    prelude_loader #(
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .uart_rx    (uart_rx),
        .prog_we    (prog_we),
        .prog_addr  (prog_addr),
        .prog_data  (prog_data),
        .cpu_reset  (cpu_reset),
        .busy       (busy),
        .load_done  (load_done),
        .load_error (load_error)
    );

    always #5 clk = ~clk;

    typedef logic [7:0] byte_q_t[$];
    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_w;
    int  tests = 0;
    int  fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            if (prog_we === 1'b1) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected no write",
                             prog_addr, prog_data);
                end else begin
                    mon_w = exp_q.pop_front();
                    check("write_addr", {24'h0, prog_addr}, {24'h0, mon_w.addr});
                    check("write_data", {24'h0, prog_data}, {24'h0, mon_w.data});
                end
            end
            if (busy === 1'b1) check("cpu_reset_while_busy", {31'h0, cpu_reset}, 32'd1);
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit stop_ok);
        uart_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        uart_rx = stop_ok;
        repeat (CPB) @(negedge clk);
        uart_rx = 1'b1;
        repeat (2 * CPB) @(negedge clk);
    endtask

    task automatic expect_status(input string tag, input bit exp_done, input bit exp_err,
                                 input logic [7:0] exp_addr);
        int waited;
        waited = 0;
        while (!(load_done === 1'b1 || load_error === 1'b1) && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        check({tag, "_status_wait"}, {31'h0, waited >= 40}, 32'd0);
        repeat (2) @(negedge clk);
        check({tag, "_load_done"},  {31'h0, load_done},  {31'h0, exp_done});
        check({tag, "_load_error"}, {31'h0, load_error}, {31'h0, exp_err});
        check({tag, "_cpu_reset"},  {31'h0, cpu_reset},  {31'h0, !exp_done});
        check({tag, "_busy"},       {31'h0, busy},       32'd0);
        check({tag, "_pending"},    exp_q.size(),        32'd0);
        check({tag, "_prog_addr"},  {24'h0, prog_addr},  {24'h0, exp_addr});
    endtask

    // Reference: writes go to 0..L-1, image is good unless a checksum is
    // present and wrong; prog_addr ends at L mod 256.
    task automatic send_frame(input string tag, input byte_q_t data, input bit corrupt);
        logic [7:0] sum;
        wr_t        w;
        int         n;
        n   = data.size();
        sum = 8'h00;
        foreach (data[i]) begin
            sum    = sum + data[i];
            w.addr = 8'(i);
            w.data = data[i];
            exp_q.push_back(w);
        end
        send_byte(8'hA5, 1'b1);
        send_byte(8'(n), 1'b1);
        foreach (data[i]) send_byte(data[i], 1'b1);
        if (HAS_SUM) send_byte(corrupt ? sum + 8'd1 : sum, 1'b1);
        expect_status(tag, !(HAS_SUM && corrupt), HAS_SUM && corrupt, 8'(n));
    endtask

    task automatic send_garbage(input byte_q_t g);
        foreach (g[i]) send_byte(g[i], 1'b1);
    endtask

    initial begin
        byte_q_t    q;
        logic [7:0] gb;
        int         len;

        repeat (3) @(negedge clk);
        check("rst_cpu_reset",  {31'h0, cpu_reset},  32'd1);
        check("rst_prog_we",    {31'h0, prog_we},    32'd0);
        check("rst_prog_addr",  {24'h0, prog_addr},  32'd0);
        check("rst_prog_data",  {24'h0, prog_data},  32'd0);
        check("rst_busy",       {31'h0, busy},       32'd0);
        check("rst_load_done",  {31'h0, load_done},  32'd0);
        check("rst_load_error", {31'h0, load_error}, 32'd0);
        reset = 1'b0;
        repeat (4) @(negedge clk);

        send_frame("basic", '{8'h11, 8'h22, 8'h33}, 1'b0);

        send_garbage('{8'h00, 8'hFF, 8'h5A});
        send_frame("after_garbage", '{8'h7E}, 1'b0);

        send_frame("bad_sum", '{8'h01, 8'h02}, 1'b1);
        send_frame("recover", '{8'h09}, 1'b0);

        q = {};
        for (int i = 0; i < 256; i++) q.push_back(8'h01);
        send_frame("full_256", q, 1'b0);

        // Framing error on the first data byte: no write, image invalid.
        send_byte(8'hA5, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h44, 1'b0);
        expect_status("ferr", 1'b0, 1'b1, 8'h00);

        // Reset mid-frame, then remaining bytes must be ignored.
        wr_t_push(8'h00, 8'h11);
        send_byte(8'hA5, 1'b1);
        send_byte(8'h03, 1'b1);
        send_byte(8'h11, 1'b1);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("midrst_cpu_reset",  {31'h0, cpu_reset},  32'd1);
        check("midrst_busy",       {31'h0, busy},       32'd0);
        check("midrst_load_done",  {31'h0, load_done},  32'd0);
        check("midrst_load_error", {31'h0, load_error}, 32'd0);
        check("midrst_prog_addr",  {24'h0, prog_addr},  32'd0);
        send_garbage('{8'h22, 8'h33});
        repeat (4) @(negedge clk);
        check("midrst_pending",    exp_q.size(),        32'd0);
        check("midrst_idle_busy",  {31'h0, busy},       32'd0);
        check("midrst_idle_done",  {31'h0, load_done},  32'd0);
        send_frame("post_reset", '{8'h55, 8'hAA}, 1'b0);

        for (int f = 0; f < 8; f++) begin
            for (int k = 0; k < int'($urandom_range(0, 3)); k++) begin
                gb = 8'($urandom);
                if (gb == 8'hA5) gb = 8'h5A;
                send_byte(gb, $urandom_range(0, 4) != 0);
            end
            len = int'($urandom_range(1, 12));
            q = {};
            for (int i = 0; i < len; i++) q.push_back(8'($urandom));
            send_frame("random", q, $urandom_range(0, 3) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    task automatic wr_t_push(input logic [7:0] a, input logic [7:0] d);
        wr_t w;
        w.addr = a;
        w.data = d;
        exp_q.push_back(w);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
